// File: rtl/i2c_pkg.sv
// Shared encodings for the two-requester I2C transaction arbiter: engine
// command codes, sequencer states and the default command timeout.
package i2c_pkg;

    localparam int NREQ = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_START = 3'd1,
        CMD_WRITE = 3'd2,
        CMD_READ  = 3'd3,
        CMD_STOP  = 3'd4
    } eng_cmd_t;

    // Each bus phase has an issue state (strobe goes out next cycle) and a wait state.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_START_W,
        ST_ADDR,
        ST_ADDR_W,
        ST_DATA,
        ST_DATA_W,
        ST_STOP,
        ST_STOP_W,
        ST_RESP
    } state_t;

    function automatic logic is_wait_state(state_t s);
        return (s == ST_START_W) || (s == ST_ADDR_W) || (s == ST_DATA_W) || (s == ST_STOP_W);
    endfunction

    function automatic eng_cmd_t phase_cmd(state_t s, logic rw);
        eng_cmd_t cmd;
        cmd = CMD_NONE;
        case (s)
            ST_START, ST_START_W: cmd = CMD_START;
            ST_ADDR,  ST_ADDR_W:  cmd = CMD_WRITE;
            ST_DATA,  ST_DATA_W:  cmd = rw ? CMD_READ : CMD_WRITE;
            ST_STOP,  ST_STOP_W:  cmd = CMD_STOP;
            default:              cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/i2c_rr_arb_2.sv
// Two-way round-robin picker; the pointer moves past the winner on each grant
// so the other requester has priority next time.
module i2c_rr_arb_2
    import i2c_pkg::*;
(
    input  logic            clk,
    input  logic            srst,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            winner,
    output logic [NREQ-1:0] grant
);

    logic rr_ptr_reg;

    assign winner = req[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = take && (winner == 1'(gi));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_ptr_reg <= 1'b0;
        end else if (take) begin
            rr_ptr_reg <= ~winner;
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C byte engine between two requesters and sequences a single-byte
// START / addr+RW / data / STOP transaction. Define I2C_TIMEOUT_EN for a per-command timeout.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rw,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_nack,
    output logic [2:0]  eng_cmd,
    output logic        eng_cmd_valid,
    output logic [7:0]  eng_txdata,
    input  logic        eng_done,
    input  logic        eng_nack,
    input  logic [7:0]  eng_rxdata
);

    state_t state_reg, state_next;

    logic            winner;
    logic [NREQ-1:0] grant;
    logic            take;

    logic [6:0] addr_arr  [NREQ];
    logic [7:0] wdata_arr [NREQ];

    logic       owner_reg, rw_reg, nack_reg;
    logic [6:0] addr_reg;
    logic [7:0] wdata_reg, rdata_reg;

    eng_cmd_t        eng_cmd_reg, eng_cmd_next;
    logic            eng_cmd_valid_reg, eng_cmd_valid_next;
    logic [7:0]      eng_txdata_reg, eng_txdata_next;
    logic [NREQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [7:0]      rsp_rdata_reg, rsp_rdata_next;
    logic            rsp_nack_reg, rsp_nack_next;

    logic wait_st, timeout, wait_end;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
        assign addr_arr[gi]  = req_addr[gi*7 +: 7];
        assign wdata_arr[gi] = req_wdata[gi*8 +: 8];
    end

    assign take = (state_reg == ST_GRANT);

    i2c_rr_arb_2 u_arb (
        .clk    (CLK),
        .srst   (RST),
        .req    (req_valid),
        .take   (take),
        .winner (winner),
        .grant  (grant)
    );

    assign wait_st  = is_wait_state(state_reg);
    assign wait_end = wait_st && (eng_done || timeout);

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Restarts in every wait state; fires after TIMEOUT_CYCLES cycles without eng_done.
    always_ff @(posedge CLK) begin
        if (RST || !wait_st || eng_done) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout = wait_st && !eng_done && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (|req_valid) state_next = ST_GRANT;
            ST_GRANT:   state_next = ST_START;
            ST_START:   state_next = ST_START_W;
            ST_START_W: begin
                if (eng_done)     state_next = ST_ADDR;
                else if (timeout) state_next = ST_STOP;
            end
            ST_ADDR:    state_next = ST_ADDR_W;
            ST_ADDR_W: begin
                if (eng_done)     state_next = eng_nack ? ST_STOP : ST_DATA;
                else if (timeout) state_next = ST_STOP;
            end
            ST_DATA:    state_next = ST_DATA_W;
            ST_DATA_W:  if (wait_end) state_next = ST_STOP;
            ST_STOP:    state_next = ST_STOP_W;
            ST_STOP_W:  if (wait_end) state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered, so each strobe appears the cycle after its issue state.
    always_comb begin
        eng_cmd_next       = CMD_NONE;
        eng_txdata_next    = 8'h00;
        eng_cmd_valid_next = (state_reg == ST_START) || (state_reg == ST_ADDR) ||
                             (state_reg == ST_DATA)  || (state_reg == ST_STOP);
        if (!wait_end) begin
            eng_cmd_next = phase_cmd(state_reg, rw_reg);
        end
        if (eng_cmd_next == CMD_WRITE) begin
            eng_txdata_next = ((state_reg == ST_ADDR) || (state_reg == ST_ADDR_W)) ?
                              {addr_reg, rw_reg} : wdata_reg;
        end
        rsp_rdata_next = (state_reg == ST_RESP) ? rdata_reg : 8'h00;
        rsp_nack_next  = (state_reg == ST_RESP) && nack_reg;
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
        assign rsp_valid_next[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            eng_cmd_reg       <= CMD_NONE;
            eng_cmd_valid_reg <= 1'b0;
            eng_txdata_reg    <= 8'h00;
            rsp_valid_reg     <= '0;
            rsp_rdata_reg     <= 8'h00;
            rsp_nack_reg      <= 1'b0;
            owner_reg         <= 1'b0;
            rw_reg            <= 1'b0;
            addr_reg          <= 7'h00;
            wdata_reg         <= 8'h00;
            rdata_reg         <= 8'h00;
            nack_reg          <= 1'b0;
        end else begin
            eng_cmd_reg       <= eng_cmd_next;
            eng_cmd_valid_reg <= eng_cmd_valid_next;
            eng_txdata_reg    <= eng_txdata_next;
            rsp_valid_reg     <= rsp_valid_next;
            rsp_rdata_reg     <= rsp_rdata_next;
            rsp_nack_reg      <= rsp_nack_next;
            case (state_reg)
                ST_GRANT: begin
                    owner_reg <= winner;
                    rw_reg    <= req_rw[winner];
                    addr_reg  <= addr_arr[winner];
                    wdata_reg <= wdata_arr[winner];
                    rdata_reg <= 8'h00;
                    nack_reg  <= 1'b0;
                end
                ST_ADDR_W: begin
                    if (eng_done)     nack_reg <= eng_nack;
                    else if (timeout) nack_reg <= 1'b1;
                end
                ST_DATA_W: begin
                    if (eng_done) begin
                        if (rw_reg) begin
                            rdata_reg <= eng_rxdata;
                            nack_reg  <= 1'b0;
                        end else begin
                            nack_reg  <= eng_nack;
                        end
                    end else if (timeout) begin
                        nack_reg <= 1'b1;
                    end
                end
                ST_START_W, ST_STOP_W: begin
                    if (timeout) nack_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = grant;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_nack      = rsp_nack_reg;
    assign eng_cmd       = eng_cmd_reg;
    assign eng_cmd_valid = eng_cmd_valid_reg;
    assign eng_txdata    = eng_txdata_reg;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one I2C byte engine between two requesters, e.g. a config loader and a host port. Grants one requester at a time, round-robin.
Sequences the granted single-byte transaction as START, address+R/W byte, data byte (write or read), STOP.
Returns read data and ACK status to the owning requester.
Sits between the requester logic and the existing SDA byte engine in Main.

Parameters:
NREQ, 2, number of requesters; fixed at 2, round-robin pointer is 1 bit.
TIMEOUT_CYCLES, 1024, max CLK cycles per engine command (used only when the optional feature is enabled).

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
req_valid  in  2  per-requester transaction request
req_rw  in  2  per requester: 1 = read, 0 = write
req_addr  in  14  {addr1[6:0], addr0[6:0]}, 7-bit slave addresses
req_wdata  in  16  {wdata1, wdata0}, write bytes
req_ready  out  2  one-hot, one-cycle acceptance pulse
rsp_valid  out  2  one-hot, one-cycle completion pulse
rsp_rdata  out  8  read byte, valid with rsp_valid
rsp_nack  out  1  1 = slave NACK or timeout, valid with rsp_valid
eng_cmd  out  3  1 START, 2 WRITE, 3 READ, 4 STOP; 0 none
eng_cmd_valid  out  1  one-cycle command strobe
eng_txdata  out  8  byte for WRITE
eng_done  in  1  one-cycle pulse, command finished
eng_nack  in  1  slave NACK on last WRITE, valid with eng_done
eng_rxdata  in  8  byte from READ, valid with eng_done

Behaviour:
- Reset (RST=1 at a CLK edge):
  - all outputs 0, state IDLE, rr_ptr=0.
  - RST mid-transaction aborts immediately. No STOP is issued; the engine is reset by the same RST.
- IDLE: if any req_valid, go to GRANT next cycle.
- GRANT:
  - Winner is req[rr_ptr] if valid, else the other requester.
  - Pulse req_ready[winner] for one cycle.
  - Latch addr, rw, wdata and owner. Requester inputs are don't-care afterwards.
  - rr_ptr <= ~winner, so the loser gets priority next time.
- START: pulse eng_cmd_valid with cmd=1, then wait for eng_done.
- ADDR:
  - Pulse WRITE with eng_txdata={addr,rw}, then wait for eng_done.
  - If eng_nack: set the nack flag and go to STOP. Otherwise go to DATA.
- DATA:
  - Write: pulse WRITE with wdata, wait for eng_done, set nack flag = eng_nack.
  - Read: pulse READ, latch eng_rxdata on eng_done, nack flag = 0.
- STOP: pulse STOP, wait for eng_done, go to RESP.
- RESP:
  - Pulse rsp_valid[owner] for one cycle, with rsp_rdata and rsp_nack held valid in the same cycle.
  - rsp_rdata = 0 for writes.
  - Return to IDLE. Minimum gap between transactions is 1 cycle.
- Command strobes:
  - eng_cmd_valid is exactly one cycle per command, issued the cycle after entering the state.
  - eng_cmd and eng_txdata hold until eng_done.
  - eng_done outside a wait state is ignored.
- Simultaneous requests: round-robin as above. After reset, requester 0 wins a tie.
- A requester holding req_valid through its own response is re-arbitrated normally; no starvation, at most 1 transaction of wait.
- Latency with an ideal engine (eng_done the cycle after the strobe) is 14 cycles from GRANT to rsp_valid.

Optional Feature:
I2C_TIMEOUT_EN:
- Defined: a counter runs in each wait state. If it reaches TIMEOUT_CYCLES without eng_done, abort to STOP; a STOP timeout goes straight to RESP. rsp_nack=1.
- Undefined: no counter, waits forever.

Decomposition:
- Package i2c_pkg: eng_cmd encodings (CMD_NONE/START/WRITE/READ/STOP), state enum, TIMEOUT_CYCLES default.
- Natural sub-module: i2c_rr_arb_2, the 2-way round-robin picker with pointer.

Test Plan:
- Write: req0 addr=0x33, wdata=0xF0, engine ACKs all.
  - Commands observed: START, WRITE 0x66, WRITE 0xF0, STOP.
  - rsp_valid=2'b01, rsp_nack=0.
- Read: req1 addr=0x50, rw=1, engine returns 0xA5.
  - WRITE 0xA1, then READ.
  - rsp_valid=2'b10, rsp_rdata=0xA5.
- Address NACK: eng_nack=1 on the address byte.
  - No DATA command; STOP is still issued.
  - rsp_nack=1.
- Contention: both requests held continuously.
  - Grants alternate 0,1,0,1.
  - Each rsp_valid matches its grant owner.
- RST asserted during DATA wait: the next cycle all outputs are 0 and state is IDLE. A fresh req0 is granted normally.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=16: engine never finishes START. STOP is issued, then rsp_nack=1.
